// File: rtl/clk_infra_lock_seq.sv
// MMCM reset/lock supervisor: qualifies lock, applies a
// fine-phase offset, then releases domain resets in order.
module clk_infra_lock_seq #(
  parameter int NUM_DOMAINS   = 4,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGGER       = 8,
  parameter int PS_W          = 10,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mmcm_locked,
  output logic                   mmcm_rst,
  output logic                   psen,
  output logic                   psincdec,
  input  logic                   psdone,
  input  logic signed [PS_W-1:0] ps_target,
  input  logic                   ps_load,
  output logic signed [PS_W-1:0] ps_current,
  output logic                   ps_busy,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [CNT_W-1:0]       relock_count,
  output logic [CNT_W-1:0]       retry_count
);

  localparam int CW = $clog2(LOCK_TIMEOUT + RST_CYCLES +
                             STABLE_CYCLES +
                             NUM_DOMAINS * STAGGER + 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_STABLE,
    S_PHASE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                  r_state, w_state_n;
  logic [CW-1:0]           r_cnt, w_cnt_n, w_cnt_inc;
  logic                    r_lk_m, r_lk;
  logic                    r_pend, w_pend_n;
  logic                    r_psen, w_psen_n;
  logic                    r_incdec, w_incdec_n;
  logic signed [PS_W-1:0]  r_cur, w_cur_n;
  logic signed [PS_W-1:0]  r_tgt, w_tgt_n;
  logic [NUM_DOMAINS-1:0]  r_dom, w_dom_n;
  logic [CNT_W-1:0]        r_relock, w_relock_n;
  logic [CNT_W-1:0]        r_retry, w_retry_n;
  logic                    r_mmcm_rst, r_busy, r_ready;
  logic                    w_locked_st;

  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_locked_st = (r_state == S_PHASE) ||
                       (r_state == S_RELEASE) ||
                       (r_state == S_RUN);

  // Two-flop synchroniser for the asynchronous LOCKED input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lk_m <= 1'b0;
      r_lk   <= 1'b0;
    end else begin
      r_lk_m <= mmcm_locked;
      r_lk   <= r_lk_m;
    end
  end

  // Next-state, phase stepping, release and counter logic
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_pend_n   = r_pend;
    w_psen_n   = 1'b0;
    w_incdec_n = r_incdec;
    w_cur_n    = r_cur;
    w_tgt_n    = r_tgt;
    w_dom_n    = r_dom;
    w_relock_n = r_relock;
    w_retry_n  = r_retry;
    if (ps_load) w_tgt_n = ps_target;
    unique case (r_state)
      S_HOLD: begin
        if (r_cnt == CW'(RST_CYCLES - 1)) begin
          w_state_n = S_WAIT;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = w_cnt_inc;
        end
      end
      S_WAIT: begin
        if (r_lk) begin
          w_state_n = S_STABLE;
          w_cnt_n   = '0;
        end else if (r_cnt == CW'(LOCK_TIMEOUT - 1)) begin
          w_state_n = S_HOLD;
          w_cnt_n   = '0;
          if (r_retry != '1) w_retry_n = r_retry + CNT_W'(1);
        end else begin
          w_cnt_n = w_cnt_inc;
        end
      end
      S_STABLE: begin
        if (!r_lk) begin
          w_state_n = S_WAIT;
          w_cnt_n   = '0;
        end else if (r_cnt == CW'(STABLE_CYCLES - 1)) begin
          w_state_n = S_PHASE;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = w_cnt_inc;
        end
      end
      S_PHASE: begin
        if (r_pend) begin
          if (psdone) begin
            w_pend_n = 1'b0;
            w_cur_n  = r_incdec ? r_cur + PS_W'(1)
                                : r_cur - PS_W'(1);
          end
        end else if (r_cur != w_tgt_n) begin
          w_psen_n   = 1'b1;
          w_pend_n   = 1'b1;
          w_incdec_n = (w_tgt_n > r_cur);
        end else if (|r_dom) begin
          w_state_n  = S_RELEASE;
          w_cnt_n    = '0;
          w_dom_n[0] = 1'b0;
        end else begin
          w_state_n = S_RUN;
        end
      end
      S_RELEASE: begin
        if (r_dom == '0) begin
          w_state_n = S_RUN;
        end else begin
          w_cnt_n = w_cnt_inc;
          for (int i = 1; i < NUM_DOMAINS; i++) begin
            if (w_cnt_inc == CW'(i * STAGGER)) w_dom_n[i] = 1'b0;
          end
        end
      end
      S_RUN: begin
        // Also catches targets loaded during RELEASE
        if (w_tgt_n != r_cur) w_state_n = S_PHASE;
      end
      default: w_state_n = S_HOLD;
    endcase
    // Lock loss after qualification restarts from MMCM reset
    if (w_locked_st && !r_lk) begin
      w_state_n = S_HOLD;
      w_cnt_n   = '0;
      w_pend_n  = 1'b0;
      w_psen_n  = 1'b0;
      w_cur_n   = '0;
      w_dom_n   = '1;
      if (r_relock != '1) w_relock_n = r_relock + CNT_W'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_HOLD;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_psen     <= 1'b0;
      r_incdec   <= 1'b0;
      r_cur      <= '0;
      r_tgt      <= '0;
      r_dom      <= '1;
      r_relock   <= '0;
      r_retry    <= '0;
      r_mmcm_rst <= 1'b1;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_pend     <= w_pend_n;
      r_psen     <= w_psen_n;
      r_incdec   <= w_incdec_n;
      r_cur      <= w_cur_n;
      r_tgt      <= w_tgt_n;
      r_dom      <= w_dom_n;
      r_relock   <= w_relock_n;
      r_retry    <= w_retry_n;
      r_mmcm_rst <= (w_state_n == S_HOLD);
      r_busy     <= (w_state_n == S_PHASE);
      r_ready    <= (w_state_n == S_RUN);
    end
  end

  assign mmcm_rst     = r_mmcm_rst;
  assign psen         = r_psen;
  assign psincdec     = r_incdec;
  assign ps_current   = r_cur;
  assign ps_busy      = r_busy;
  assign domain_rst   = r_dom;
  assign ready        = r_ready;
  assign relock_count = r_relock;
  assign retry_count  = r_retry;

endmodule

// File: tb/tb_clk_infra_lock_seq.sv
// Directed bench for clk_infra_lock_seq: bring-up, timeout,
// phase offset, glitchy lock, lock loss and retargeting.
module tb_clk_infra_lock_seq;

  localparam int ND = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              locked;
  logic              mmcm_rst;
  logic              psen;
  logic              psincdec;
  logic              psdone;
  logic              psdone_r = 1'b0;
  logic              psdone_m = 1'b0;
  logic signed [9:0] ps_target;
  logic              ps_load;
  logic signed [9:0] ps_current;
  logic              ps_busy;
  logic [ND-1:0]     domain_rst;
  logic              ready;
  logic [7:0]        relock_count;
  logic [7:0]        retry_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = 0;
  int psen_cnt = 0;
  int inc_cnt = 0;
  int n, bad, lat_clean, lat_g, p0, i0;

  assign psdone = psdone_r | psdone_m;

  always #5 clk = ~clk;

  clk_infra_lock_seq #(
    .NUM_DOMAINS(ND),
    .RST_CYCLES(4),
    .LOCK_TIMEOUT(100),
    .STABLE_CYCLES(16),
    .STAGGER(8),
    .PS_W(10),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mmcm_locked(locked),
    .mmcm_rst(mmcm_rst),
    .psen(psen),
    .psincdec(psincdec),
    .psdone(psdone),
    .ps_target(ps_target),
    .ps_load(ps_load),
    .ps_current(ps_current),
    .ps_busy(ps_busy),
    .domain_rst(domain_rst),
    .ready(ready),
    .relock_count(relock_count),
    .retry_count(retry_count)
  );

  // MMCM phase-shift model: PSDONE 12 cycles after PSEN
  initial begin
    forever begin
      @(posedge clk); #1;
      if (psen) begin
        repeat (11) @(posedge clk);
        #1 psdone_r = 1'b1;
        @(posedge clk);
        #1 psdone_r = 1'b0;
      end
    end
  end

  // Event counters for psen/psincdec/psdone
  initial begin
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (psdone) last_done = cyc;
      if (psen) psen_cnt++;
      if (psen && psincdec) inc_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_dom(input int budget, output int m);
    m = 0;
    while (domain_rst == 4'hF && m < budget) begin
      step(1);
      m++;
    end
  endtask

  task automatic wait_ready(input int budget, output int m);
    m = 0;
    while (!ready && m < budget) begin
      step(1);
      m++;
    end
  endtask

  initial begin
    rst = 1'b1;
    locked = 1'b0;
    ps_target = '0;
    ps_load = 1'b0;
    step(3);
    check("rst_mmcm_rst", mmcm_rst, 1);
    check("rst_psen", psen, 0);
    check("rst_psincdec", psincdec, 0);
    check("rst_ps_current", ps_current, 0);
    check("rst_ps_busy", ps_busy, 0);
    check("rst_domain_rst", domain_rst, 4'hF);
    check("rst_ready", ready, 0);
    check("rst_relock", relock_count, 0);
    check("rst_retry", retry_count, 0);

    // Clean bring-up
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (mmcm_rst) n++;
      step(1);
    end
    check("up_mmcm_rst_len", n, 4);
    locked = 1'b1;
    wait_dom(300, lat_clean);
    check("up_rel_in_budget", lat_clean < 300, 1);
    check("up_dom0", domain_rst, 4'b1110);
    step(7);
    check("up_dom0_hold", domain_rst, 4'b1110);
    step(1);
    check("up_dom1", domain_rst, 4'b1100);
    step(8);
    check("up_dom2", domain_rst, 4'b1000);
    step(8);
    check("up_dom3", domain_rst, 4'b0000);
    check("up_ready_lag", ready, 0);
    step(1);
    check("up_ready", ready, 1);
    check("up_no_psen", psen_cnt, 0);
    check("up_mmcm_rst_low", mmcm_rst, 0);

    // Retarget in RUN
    p0 = psen_cnt;
    i0 = inc_cnt;
    ps_target = 10'sd2;
    ps_load = 1'b1;
    step(1);
    ps_load = 1'b0;
    check("rt_ready_drop", ready, 0);
    check("rt_busy", ps_busy, 1);
    check("rt_dom_kept", domain_rst, 0);
    n = 0;
    bad = 0;
    while (!ready && n < 200) begin
      if (domain_rst != '0) bad++;
      step(1);
      n++;
    end
    check("rt_ready_back", ready, 1);
    check("rt_dom_stayed", bad, 0);
    check("rt_psen", psen_cnt - p0, 2);
    check("rt_inc", inc_cnt - i0, 2);
    check("rt_cur", ps_current, 2);
    p0 = psen_cnt;
    ps_load = 1'b1;
    step(1);
    ps_load = 1'b0;
    check("rt_same_ready", ready, 1);
    step(30);
    check("rt_same_no_psen", psen_cnt - p0, 0);
    psdone_m = 1'b1;
    step(1);
    psdone_m = 1'b0;
    step(2);
    check("stray_done_cur", ps_current, 2);
    check("stray_done_ready", ready, 1);

    // Run-time lock loss
    locked = 1'b0;
    step(2);
    check("loss_sync_delay", domain_rst, 0);
    step(1);
    check("loss_dom", domain_rst, 4'hF);
    check("loss_ready", ready, 0);
    check("loss_relock", relock_count, 1);
    check("loss_cur", ps_current, 0);
    check("loss_busy", ps_busy, 0);
    check("loss_mmcm_rst", mmcm_rst, 1);
    locked = 1'b1;
    p0 = psen_cnt;
    wait_ready(500, n);
    check("relock_ready", ready, 1);
    check("relock_cur", ps_current, 2);
    check("relock_psen", psen_cnt - p0, 2);
    check("relock_count", relock_count, 1);

    // Mid-run reset, then timeout retries
    rst = 1'b1;
    locked = 1'b0;
    #1;
    check("mid_rst_dom", domain_rst, 4'hF);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_relock", relock_count, 0);
    step(2);
    rst = 1'b0;
    step(103);
    check("to_wait_low", mmcm_rst, 0);
    check("to_retry0", retry_count, 0);
    step(1);
    check("to_repulse", mmcm_rst, 1);
    check("to_retry1", retry_count, 1);
    step(3);
    check("to_repulse_end", mmcm_rst, 1);
    step(1);
    check("to_repulse_off", mmcm_rst, 0);
    step(142);
    check("to_retry2", retry_count, 2);
    check("to_dom", domain_rst, 4'hF);
    rst = 1'b1;
    #1;
    check("to_rst_clear", retry_count, 0);
    step(2);
    rst = 1'b0;

    // Phase offset loaded before lock
    ps_target = -10'sd3;
    ps_load = 1'b1;
    step(1);
    ps_load = 1'b0;
    locked = 1'b1;
    p0 = psen_cnt;
    i0 = inc_cnt;
    wait_dom(600, n);
    check("ph_rel_in_budget", n < 600, 1);
    check("ph_psen", psen_cnt - p0, 3);
    check("ph_dir", inc_cnt - i0, 0);
    check("ph_cur_at_rel", ps_current, -3);
    check("ph_rel_after_done", cyc > last_done, 1);
    check("ph_busy_off", ps_busy, 0);
    wait_ready(200, n);
    check("ph_ready", ready, 1);

    // Glitchy lock during qualification
    rst = 1'b1;
    locked = 1'b0;
    step(2);
    rst = 1'b0;
    locked = 1'b1;
    step(13);
    locked = 1'b0;
    step(2);
    locked = 1'b1;
    check("gl_dom_held", domain_rst, 4'hF);
    wait_dom(300, lat_g);
    check("gl_fresh_qual", lat_g, lat_clean);
    check("gl_relock", relock_count, 0);
    check("gl_retry", retry_count, 0);
    wait_ready(200, n);
    check("gl_ready", ready, 1);
    check("gl_dom_clear", domain_rst, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
